mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port word RAM between the core's instruction-fetch port
//  (IF) and its load/store port (D), so CoreRiscV can run from a unified
//  memory. Each access uses a req/gnt/rvalid handshake. Arbitration is
//  round-robin. Out-of-range addresses return an error response, and the
//  block counts lost-arbitration cycles for performance debug.
// PARAMETERS
//  RAM_SIZE  512  RAM depth in 32-bit words; valid byte addresses are 0..4*RAM_SIZE-1
//  MEM_LAT   1    RAM read latency in cycles, from mem_en to mem_rdata valid (>=1)
//  CNT_W     16   width of conflict_cnt
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  if_req        in   1      IF request; held with if_addr until if_gnt
//  if_addr       in   32     IF byte address; bits [1:0] ignored
//  if_gnt        out  1      IF request accepted this cycle
//  if_rvalid     out  1      IF response valid, 1-cycle pulse
//  if_rdata      out  32     IF read data; qualified by if_rvalid
//  if_err        out  1      IF address out of range; qualified by if_rvalid
//  d_req         in   1      D request; held with d_* until d_gnt
//  d_we          in   1      1 = write, 0 = read
//  d_addr        in   32     D byte address; bits [1:0] ignored
//  d_be          in   4      D write byte enables
//  d_wdata       in   32     D write data
//  d_gnt         out  1      D request accepted this cycle
//  d_rvalid      out  1      D response (read data or write ack), 1-cycle pulse
//  d_rdata       out  32     D read data; 0 for writes
//  d_err         out  1      D address out of range; qualified by d_rvalid
//  mem_en        out  1      RAM access strobe
//  mem_we        out  1      RAM write strobe
//  mem_addr      out  W      RAM word address, W = $clog2(RAM_SIZE)
//  mem_be        out  4      RAM byte enables
//  mem_wdata     out  32     RAM write data
//  mem_rdata     in   32     RAM read data, MEM_LAT cycles after mem_en
//  conflict_cnt  out  CNT_W  saturating count of cycles in which a request lost arbitration
// BEHAVIOUR
//  Reset
//  - All outputs are 0; FSM = IDLE; last_owner = D, so IF wins the first tie.
//  - Assertion mid-access aborts the access: no rvalid is issued for it afterwards.
//  FSM states: IDLE, BUSY
//  - IDLE: if any req, gnt goes high to the winner combinationally in the same cycle.
//    - mem_en, mem_we, mem_addr, mem_be and mem_wdata are driven combinationally
//      from the winner; IF always gives mem_we = 0.
//    - Go to BUSY. Latch owner, err = (addr[31:2] >= RAM_SIZE) and we.
//  - BUSY: a down-counter loads MEM_LAT-1 at grant and decrements each cycle.
//    - While count != 0, no gnt is issued and mem_en = 0.
//    - When count == 0, the owner's rvalid pulses. rdata = mem_rdata for a read,
//      and 0 for a write or an error.
//    - In that same cycle the arbiter behaves as IDLE, so the next grant may be
//      issued. Back-to-back throughput is one access per MEM_LAT cycles.
//  Arbitration
//  - If only one port requests, it wins.
//  - If both request, the port that is not last_owner wins; last_owner updates on every grant.
//  - A request is never dropped; the loser keeps req high and wins the next arbitration.
//  Errors
//  - An out-of-range access gets gnt as normal, but mem_en = 0.
//  - Its response follows the normal latency with err = 1 and rdata = 0; no RAM write occurs.
//  Conflict counter
//  - conflict_cnt increments by 1 in each cycle where a grant is issued and the
//    other port's req is also high.
//  - It saturates at 2^CNT_W-1.
//  Other rules
//  - Requests arriving in a BUSY cycle with count != 0 wait; gnt stays 0.
//  - req deasserted before gnt is legal; no access occurs.
//  - gnt and rvalid for different accesses may be high in the same cycle.
// TESTING
//  - Reset: rst_n=0 with if_req=d_req=1 -> all outputs 0, no mem_en. Release rst_n
//    -> if_gnt first (last_owner = D).
//  - IF read, MEM_LAT=1: if_req, if_addr=0x10, RAM[4]=0xDEADBEEF -> if_gnt in cycle N,
//    mem_addr=4; if_rvalid=1 with if_rdata=0xDEADBEEF in N+1.
//  - D write then read: d_we=1, d_addr=0x20, d_be=4'b0011, d_wdata=0x12345678 ->
//    d_rvalid ack with rdata=0. Read of 0x20 then returns 0x00005678 (RAM preset 0).
//  - Both ports request for 4 consecutive accesses -> grants alternate IF,D,IF,D;
//    conflict_cnt = 3 (last grant is uncontested if IF drops req).
//  - d_addr = 4*RAM_SIZE (0x800) write -> d_gnt, mem_en=0, d_rvalid with d_err=1,
//    and RAM contents unchanged.
//  - rst_n pulsed low in the BUSY cycle of a MEM_LAT=3 read -> no if_rvalid
//    afterwards; conflict_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between IF and D.
// Ports: if_* fetch req/gnt/rvalid, d_* load/store, mem_* RAM, conflict_cnt.
module mem_port_arbiter #(
  parameter int RAM_SIZE = 512,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = 16,
  localparam int W  = $clog2(RAM_SIZE),
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [3:0]       d_be,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [W-1:0]     mem_addr,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          owner_d_q;
  logic          last_d_q;
  logic          err_q;
  logic          we_q;

  logic          arb;
  logic          resp;
  logic          pick_d;
  logic          gnt_any;
  logic [31:0]   win_addr;
  logic          win_err;
  logic          win_we;
  logic [31:0]   rsp_data;
  logic          unused_ok;

  assign unused_ok = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resp      = rst_n && (state_q == BUSY) && (cnt_q == '0);
    arb       = rst_n && ((state_q == IDLE) || (cnt_q == '0));
    // IF wins a tie unless it owned the last grant.
    pick_d    = d_req && !(if_req && last_d_q);
    gnt_any   = arb && (if_req || d_req);
    win_addr  = pick_d ? d_addr : if_addr;
    win_err   = {2'b00, win_addr[31:2]} >= 32'(RAM_SIZE);
    win_we    = pick_d && d_we;
    if_gnt    = gnt_any && !pick_d;
    d_gnt     = gnt_any && pick_d;
    mem_en    = gnt_any && !win_err;
    mem_we    = mem_en && win_we;
    mem_addr  = mem_en ? win_addr[W+1:2] : '0;
    mem_be    = (mem_en && pick_d) ? d_be : 4'b0000;
    mem_wdata = mem_we ? d_wdata : 32'h0;
    rsp_data  = (we_q || err_q) ? 32'h0 : mem_rdata;
    if_rvalid = resp && !owner_d_q;
    d_rvalid  = resp && owner_d_q;
    if_rdata  = if_rvalid ? rsp_data : 32'h0;
    d_rdata   = d_rvalid ? rsp_data : 32'h0;
    if_err    = if_rvalid && err_q;
    d_err     = d_rvalid && err_q;
    if (gnt_any) begin
      state_d = BUSY;
      cnt_d   = LW'(MEM_LAT - 1);
    end else if (resp) begin
      state_d = IDLE;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_d_q    <= 1'b0;
      last_d_q     <= 1'b1;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_any) begin
        owner_d_q <= pick_d;
        last_d_q  <= pick_d;
        err_q     <= win_err;
        we_q      <= win_we;
      end
      if (gnt_any && if_req && d_req &&
          conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
// Two instances: MEM_LAT=1 (scoreboarded) and MEM_LAT=3 (latency/abort).
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n, ld;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  exp_t        e_s, o_s;
  logic [31:0] gold [512];

  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;
  logic [31:0] ram [512];

  logic        i3_req, i3_gnt, i3_rvalid, i3_err;
  logic [31:0] i3_addr, i3_rdata;
  logic        z1 = 1'b0;
  logic [31:0] z32 = 32'h0;
  logic [3:0]  z4 = 4'h0;
  logic        d3_gnt, d3_rvalid, d3_err;
  logic [31:0] d3_rdata;
  logic        m3_en, m3_we;
  logic [8:0]  m3_addr;
  logic [3:0]  m3_be;
  logic [31:0] m3_wdata;
  logic [31:0] p3 [3];
  logic [15:0] conflict3;
  logic [31:0] ram3 [512];

  always #5 clk = ~clk;

  mem_port_arbiter #(.RAM_SIZE(512), .MEM_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.RAM_SIZE(512), .MEM_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(i3_req), .if_addr(i3_addr), .if_gnt(i3_gnt),
    .if_rvalid(i3_rvalid), .if_rdata(i3_rdata), .if_err(i3_err),
    .d_req(z1), .d_we(z1), .d_addr(z32), .d_be(z4),
    .d_wdata(z32), .d_gnt(d3_gnt), .d_rvalid(d3_rvalid),
    .d_rdata(d3_rdata), .d_err(d3_err),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_be(m3_be), .mem_wdata(m3_wdata), .mem_rdata(p3[2]),
    .conflict_cnt(conflict3)
  );

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
      ram[4] <= 32'hDEADBEEF;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we)
        ram[mem_addr] <= (ram[mem_addr] & ~bmask(mem_be)) |
                         (mem_wdata & bmask(mem_be));
    end
  end

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 512; i++) ram3[i] <= 32'h0;
      ram3[4] <= 32'hDEADBEEF;
    end
    p3[0] <= m3_en ? ram3[m3_addr] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (if_rvalid || d_rvalid)) begin
      o_s = '{d: d_rvalid,
              data: d_rvalid ? d_rdata : if_rdata,
              err: d_rvalid ? d_err : if_err};
      chk("dual_rvalid", {if_rvalid, d_rvalid} == 2'b11, 0);
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rvalid: got %0h expected none", o_s);
      end
      if (q.size() != 0) begin
        e_s = q.pop_front();
        chk("resp", o_s, e_s);
      end
    end
  end

  task automatic acc(input bit p, input bit we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    int          n;
    logic        err;
    logic [31:0] rd;
    @(posedge clk); #1;
    if (p) begin
      d_req = 1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(p ? d_gnt : if_gnt) && n < 20);
    chk("gnt_latency", n, 1);
    err = a[31:2] >= 30'd512;
    chk("mem_en", mem_en, !err);
    chk("mem_we", mem_we, we && !err);
    if (!err) chk("mem_addr", mem_addr, a[10:2]);
    rd = (we || err) ? 32'h0 : gold[a[10:2]];
    if (we && !err)
      gold[a[10:2]] = (gold[a[10:2]] & ~bmask(be)) | (wd & bmask(be));
    q.push_back('{d: p, data: rd, err: err});
    @(posedge clk); #1;
    if_req = 0; d_req = 0; d_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) gold[i] = 32'h0;
    gold[4] = 32'hDEADBEEF;
    rst_n = 0; rst3_n = 0; ld = 1;
    if_req = 1; d_req = 1; d_we = 0; if_addr = 0; d_addr = 0;
    d_be = 0; d_wdata = 0; i3_req = 0; i3_addr = 0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {if_gnt, d_gnt, if_rvalid, d_rvalid,
                        mem_en, mem_we}, 0);
    chk("rst_mem", {mem_addr, mem_be, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, d_rdata, if_err, d_err}, 0);
    chk("rst_cnt", conflict_cnt, 0);
    @(posedge clk); #1;
    ld = 0; rst_n = 1; rst3_n = 1;
    @(negedge clk);
    chk("first_tie", {if_gnt, d_gnt}, 2'b10);
    @(posedge clk); #1;
    if_req = 0; d_req = 0; rst_n = 0;
    @(negedge clk);
    chk("abort_rvalid", if_rvalid, 0);
    chk("abort_cnt", conflict_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;

    acc(0, 0, 32'h10, 4'h0, 32'h0);
    acc(1, 1, 32'h20, 4'b0011, 32'h12345678);
    acc(0, 0, 32'h20, 4'h0, 32'h0);
    acc(1, 0, 32'h20, 4'h0, 32'h0);

    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_gnt", {if_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 0) q.push_back('{d: 0, data: gold[4], err: 0});
      else            q.push_back('{d: 1, data: gold[8], err: 0});
      @(posedge clk); #1;
      if (k == 2) if_req = 0;
      if (k == 3) d_req = 0;
    end
    @(negedge clk);
    chk("conflict_cnt", conflict_cnt, 3);

    acc(1, 1, 32'h800, 4'hF, 32'hFFFFFFFF);
    acc(0, 0, 32'h1000, 4'h0, 32'h0);
    acc(1, 1, 32'h7FC, 4'hF, 32'hAA55AA55);
    acc(1, 0, 32'h7FC, 4'h0, 32'h0);
    acc(1, 0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("err_no_write", ram[0], 32'h0);
    chk("conflict_hold", conflict_cnt, 3);

    @(posedge clk); #1;
    i3_req = 1; i3_addr = 32'h10;
    @(negedge clk);
    chk("l3_gnt", i3_gnt, 1);
    @(posedge clk); #1;
    i3_addr = 32'h14;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk("l3_busy", {i3_gnt, i3_rvalid, m3_en}, 0);
    end
    @(negedge clk);
    chk("l3_rvalid", {i3_rvalid, i3_err}, 2'b10);
    chk("l3_rdata", i3_rdata, 32'hDEADBEEF);
    chk("l3_b2b_gnt", i3_gnt, 1);
    @(posedge clk); #1;
    i3_req = 0; rst3_n = 0;
    @(posedge clk); #1;
    rst3_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("l3_abort", i3_rvalid, 0);
    end
    chk("l3_conflict", conflict3, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
